div_arbiter_seq: RTL and testbench

- Shared multi-cycle unsigned divider with a two-requester round-robin arbiter in front of it.
- Requester 0 is the calculator operation path. Requester 1 is the display binary-to-decimal converter.
- Performs one restoring-division step per clock, so one radix-2 datapath serves both clients instead of a fully unrolled combinational divider.
- Returns quotient, remainder and divide-by-zero flag, tagged with the id of the requester served.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 27 ++
 rtl/div_arbiter_seq.sv | 136 +++++++++++++
 tb/tb_div_arbiter_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the arbitrated sequential divider: FSM states,
// default operand width and the quotient returned on divide-by-zero.
package div_pkg;

  localparam int W_DEF = 32;

  // Only bit 0 matters to users; it is replicated to the instance width.
  localparam logic [W_DEF-1:0] DBZ_QUOT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, shift the quotient bit in.
module div_step
  import div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] r,
  input  logic [W-1:0] q,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] r_next,
  output logic [W-1:0] q_next
);

  logic [W:0] r_shift;
  logic [W:0] diff;
  logic       fits;

  // Widened by one bit so a remainder with its MSB set still compares correctly.
  assign r_shift = {r, q[W-1]};
  assign diff    = r_shift - {1'b0, divisor};
  assign fits    = ~diff[W];

  assign r_next = fits ? diff[W-1:0] : r_shift[W-1:0];
  assign q_next = {q[W-2:0], fits};

endmodule

// File: rtl/div_arbiter_seq.sv
// Shared radix-2 restoring divider with a two-requester round-robin arbiter.
// Requester 0 is the calculator path, requester 1 the display converter.
//
// state   | meaning
// IDLE    | waiting for a request; arbitrates and captures operands
// ITER    | one restoring step per clock, W steps in total
// DONE    | one-cycle done pulse, results valid
module div_arbiter_seq
  import div_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] dividend0,
  input  logic [W-1:0] divisor0,
  input  logic [W-1:0] dividend1,
  input  logic [W-1:0] divisor1,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         dbz
);

  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          last_id_q;
  logic [W-1:0]  dvsr_q;
  logic [W-1:0]  r_q;
  logic [W-1:0]  qs_q;
  logic          busy_q;
  logic          done_q;
  logic          done_id_q;
  logic [W-1:0]  quot_q;
  logic [W-1:0]  rem_q;
  logic          dbz_q;

  logic          grant_d;
  logic [W-1:0]  sel_dividend_d;
  logic [W-1:0]  sel_divisor_d;
  logic [W-1:0]  r_d;
  logic [W-1:0]  qs_d;

  // On a tie the requester not served last wins.
  always_comb begin
    grant_d = 1'b0;
    if (req == 2'b10)
      grant_d = 1'b1;
    else if (req == 2'b11)
      grant_d = ~last_id_q;
  end

  assign sel_dividend_d = grant_d ? dividend1 : dividend0;
  assign sel_divisor_d  = grant_d ? divisor1  : divisor0;

  div_step #(.W(W)) u_step (
    .r       (r_q),
    .q       (qs_q),
    .divisor (dvsr_q),
    .r_next  (r_d),
    .q_next  (qs_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_id_q <= 1'b1;
      dvsr_q    <= '0;
      r_q       <= '0;
      qs_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (req != 2'b00) begin
            last_id_q <= grant_d;
            done_id_q <= grant_d;
            dvsr_q    <= sel_divisor_d;
            busy_q    <= 1'b1;
            if (sel_divisor_d == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              quot_q  <= {W{DBZ_QUOT[0]}};
              rem_q   <= sel_dividend_d;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= ST_ITER;
              r_q     <= '0;
              qs_q    <= sel_dividend_d;
              cnt_q   <= '0;
              dbz_q   <= 1'b0;
            end
          end
        end
        ST_ITER: begin
          r_q   <= r_d;
          qs_q  <= qs_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            quot_q  <= qs_d;
            rem_q   <= r_d;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_div_arbiter_seq.sv
// Directed bench for div_arbiter_seq: a cycle-count/arithmetic model checked
// every cycle, plus literal expectations for each scenario.
module tb_div_arbiter_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] dividend0, divisor0, dividend1, divisor1;
  logic         busy, done, done_id, dbz;
  logic [W-1:0] quotient, remainder;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_arbiter_seq #(.W(W), .CW(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .dividend0 (dividend0),
    .divisor0  (divisor0),
    .dividend1 (dividend1),
    .divisor1  (divisor1),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_rem counts cycles of busy left; done is the last of them.
  int           m_rem   = 0;
  logic         m_last  = 1'b1;
  logic         m_id    = 1'b0;
  logic         m_dbz   = 1'b0;
  logic [W-1:0] m_q     = '0;
  logic [W-1:0] m_r     = '0;
  logic [W-1:0] m_pq    = '0;
  logic [W-1:0] m_pr    = '0;
  logic         m_g;
  logic [W-1:0] m_a, m_b;
  bit           started = 1'b0;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_rem = 0; m_last = 1'b1; m_id = 1'b0; m_dbz = 1'b0; m_q = '0; m_r = '0;
    end else if (m_rem == 0) begin
      if (req != 2'b00) begin
        if (req == 2'b11) m_g = ~m_last;
        else              m_g = req[1];
        m_last = m_g;
        m_id   = m_g;
        m_a    = m_g ? dividend1 : dividend0;
        m_b    = m_g ? divisor1  : divisor0;
        if (m_b == 0) begin
          m_rem = 1; m_q = '1; m_r = m_a; m_dbz = 1'b1;
        end else begin
          m_rem = W + 1; m_pq = m_a / m_b; m_pr = m_a % m_b; m_dbz = 1'b0;
        end
      end
    end else begin
      m_rem = m_rem - 1;
      if (m_rem == 1) begin
        m_q = m_pq; m_r = m_pr;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cmp_busy", 64'(busy), 64'(m_rem != 0));
      chk("cmp_done", 64'(done), 64'(m_rem == 1));
      chk("cmp_done_id", 64'(done_id), 64'(m_id));
      chk("cmp_quotient", 64'(quotient), 64'(m_q));
      chk("cmp_remainder", 64'(remainder), 64'(m_r));
      chk("cmp_dbz", 64'(dbz), 64'(m_dbz));
    end
  end

  task automatic wait_done(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < max);
    if (!done) chk("timeout_done", 64'(done), 64'd1);
  endtask

  initial begin
    int n;
    int extra;
    logic [W-1:0] exp_q[4];
    logic [W-1:0] exp_r[4];
    exp_q = '{32'd100, 32'd249, 32'd100, 32'd249};
    exp_r = '{32'd0,   32'd3,   32'd0,   32'd3};

    rst = 1'b1; req = 2'b00;
    dividend0 = '0; divisor0 = '0; dividend1 = '0; divisor1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done_id", 64'(done_id), 64'd0);
    chk("reset_quotient", 64'(quotient), 64'd0);

    // 100 / 7 from requester 0
    dividend0 = 100; divisor0 = 7; req = 2'b01;
    wait_done(40, n);
    chk("t1_latency", 64'(n), 64'd33);
    chk("t1_quotient", 64'(quotient), 64'd14);
    chk("t1_remainder", 64'(remainder), 64'd2);
    chk("t1_model_q", 64'(m_q), 64'd14);
    chk("t1_id", 64'(done_id), 64'd0);
    chk("t1_dbz", 64'(dbz), 64'd0);
    req = 2'b00;
    @(negedge clk);
    chk("t1_idle_busy", 64'(busy), 64'd0);

    // extreme operands from requester 1
    dividend1 = 32'hFFFF_FFFF; divisor1 = 1; req = 2'b10;
    wait_done(40, n);
    chk("t2a_quotient", 64'(quotient), 64'hFFFF_FFFF);
    chk("t2a_remainder", 64'(remainder), 64'd0);
    chk("t2a_id", 64'(done_id), 64'd1);
    req = 2'b00;
    @(negedge clk);
    dividend1 = 5; divisor1 = 32'hFFFF_FFFF; req = 2'b10;
    wait_done(40, n);
    chk("t2b_quotient", 64'(quotient), 64'd0);
    chk("t2b_remainder", 64'(remainder), 64'd5);
    req = 2'b00;
    @(negedge clk);

    // divide by zero
    dividend0 = 1234; divisor0 = 0; req = 2'b01;
    wait_done(5, n);
    chk("t3_latency", 64'(n), 64'd1);
    chk("t3_dbz", 64'(dbz), 64'd1);
    chk("t3_quotient", 64'(quotient), 64'hFFFF_FFFF);
    chk("t3_remainder", 64'(remainder), 64'd1234);
    chk("t3_busy", 64'(busy), 64'd1);
    req = 2'b00;
    @(negedge clk);
    chk("t3_busy_after", 64'(busy), 64'd0);

    // tie held from reset: alternating service
    rst = 1'b1;
    dividend0 = 1000; divisor0 = 10; dividend1 = 999; divisor1 = 4; req = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_done(40, n);
      chk("t4_id", 64'(done_id), 64'(k % 2));
      chk("t4_quotient", 64'(quotient), 64'(exp_q[k]));
      chk("t4_remainder", 64'(remainder), 64'(exp_r[k]));
      if (k == 3) begin
        req = 2'b00;
      end else begin
        req[k % 2] = 1'b0;
        @(negedge clk);
        req[k % 2] = 1'b1;
      end
    end
    @(negedge clk);

    // reset during ITER step 15 discards the operation
    dividend0 = 100; divisor0 = 7; req = 2'b01;
    repeat (16) @(negedge clk);
    chk("t5_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1; req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_quotient", 64'(quotient), 64'd0);
    chk("t5_remainder", 64'(remainder), 64'd0);
    chk("t5_dbz", 64'(dbz), 64'd0);
    dividend0 = 81; divisor0 = 9; req = 2'b01;
    wait_done(40, n);
    chk("t5_latency", 64'(n), 64'd33);
    chk("t5_quotient2", 64'(quotient), 64'd9);
    chk("t5_remainder2", 64'(remainder), 64'd0);
    chk("t5_id", 64'(done_id), 64'd0);
    req = 2'b00;
    @(negedge clk);

    // operands changed and request dropped after capture
    dividend0 = 200; divisor0 = 9; req = 2'b01;
    @(negedge clk);
    dividend0 = 5; req = 2'b00;
    wait_done(40, n);
    chk("t6_latency", 64'(n), 64'd32);
    chk("t6_quotient", 64'(quotient), 64'd22);
    chk("t6_remainder", 64'(remainder), 64'd2);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("t6_single_done", 64'(extra), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
